vga_sync_gen: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 36 +++
 rtl/vga_sync_gen_if.sv | 20 ++
 rtl/vga_axis_counter.sv | 26 ++
 rtl/vga_sync_gen.sv | 108 ++++++++++
 tb/tb_vga_sync_gen.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and helpers: 640x480@60 defaults, counter width, sync window math.
package vga_timing_pkg;

    localparam int unsigned COUNT_W   = 10;
    localparam int unsigned MAX_COUNT = 1 << COUNT_W;

    localparam int unsigned DEF_ACTIVE_COLS   = 640;
    localparam int unsigned DEF_H_FRONT_PORCH = 16;
    localparam int unsigned DEF_H_SYNC_WIDTH  = 96;
    localparam int unsigned DEF_H_BACK_PORCH  = 48;
    localparam int unsigned DEF_TOTAL_COLS    = DEF_ACTIVE_COLS + DEF_H_FRONT_PORCH
                                              + DEF_H_SYNC_WIDTH + DEF_H_BACK_PORCH;

    localparam int unsigned DEF_ACTIVE_ROWS   = 480;
    localparam int unsigned DEF_V_FRONT_PORCH = 10;
    localparam int unsigned DEF_V_SYNC_WIDTH  = 2;
    localparam int unsigned DEF_V_BACK_PORCH  = 33;
    localparam int unsigned DEF_TOTAL_ROWS    = DEF_ACTIVE_ROWS + DEF_V_FRONT_PORCH
                                              + DEF_V_SYNC_WIDTH + DEF_V_BACK_PORCH;

    // One extra bit so a window ending exactly at MAX_COUNT is representable.
    typedef struct packed {
        logic [COUNT_W:0] start;
        logic [COUNT_W:0] stop;
    } sync_window_t;

    function automatic sync_window_t sync_window(input int unsigned active,
                                                 input int unsigned front,
                                                 input int unsigned width);
        sync_window_t w;
        w.start = (COUNT_W+1)'(active + front);
        w.stop  = (COUNT_W+1)'(active + front + width);
        return w;
    endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Timing bundle presented by the sync generator to downstream sync-to-count and display logic.
interface vga_sync_gen_if;
    import vga_timing_pkg::*;

    logic               o_HSync;
    logic               o_VSync;
    logic [COUNT_W-1:0] o_Col_Count;
    logic [COUNT_W-1:0] o_Row_Count;
    logic               o_Active;
    logic               o_Frame_Start;

    modport master (
        output o_HSync, o_VSync, o_Col_Count, o_Row_Count, o_Active, o_Frame_Start
    );

    modport slave (
        input  o_HSync, o_VSync, o_Col_Count, o_Row_Count, o_Active, o_Frame_Start
    );

endinterface

// File: rtl/vga_axis_counter.sv
// Wrap counter for one screen axis: counts 0..LIMIT-1 while enabled, flags the terminal value.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned LIMIT = DEF_TOTAL_COLS
) (
    input  logic               i_Clk,
    input  logic               i_Rst_L,
    input  logic               i_En,
    output logic [COUNT_W-1:0] o_Count,
    output logic               o_Terminal_c
);

    localparam logic [COUNT_W-1:0] LAST = COUNT_W'(LIMIT - 1);

    assign o_Terminal_c = (o_Count == LAST);

    always_ff @(posedge i_Clk) begin : p_count
        if (!i_Rst_L) begin
            o_Count <= '0;
        end else if (i_En) begin
            o_Count <= o_Terminal_c ? '0 : o_Count + COUNT_W'(1);
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing master: column/row counters decoded into registered, mutually aligned sync,
// active-video, frame-start and position outputs.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned ACTIVE_COLS     = DEF_ACTIVE_COLS,
    parameter int unsigned H_FRONT_PORCH   = DEF_H_FRONT_PORCH,
    parameter int unsigned H_SYNC_WIDTH    = DEF_H_SYNC_WIDTH,
    parameter int unsigned H_BACK_PORCH    = DEF_H_BACK_PORCH,
    parameter int unsigned ACTIVE_ROWS     = DEF_ACTIVE_ROWS,
    parameter int unsigned V_FRONT_PORCH   = DEF_V_FRONT_PORCH,
    parameter int unsigned V_SYNC_WIDTH    = DEF_V_SYNC_WIDTH,
    parameter int unsigned V_BACK_PORCH    = DEF_V_BACK_PORCH,
    parameter int unsigned SYNC_ACTIVE_LOW = 1
) (
    input  logic           i_Clk,
    input  logic           i_Rst_L,
    input  logic           i_En,
    vga_sync_gen_if.master vga
);

    localparam int unsigned TOTAL_COLS = ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH;
    localparam int unsigned TOTAL_ROWS = ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH;

    if (TOTAL_COLS > MAX_COUNT || TOTAL_ROWS > MAX_COUNT) begin : g_size_check
        $error("vga_sync_gen: TOTAL_COLS=%0d / TOTAL_ROWS=%0d exceed counter range %0d",
               TOTAL_COLS, TOTAL_ROWS, MAX_COUNT);
    end

    localparam sync_window_t     H_WIN    = sync_window(ACTIVE_COLS, H_FRONT_PORCH, H_SYNC_WIDTH);
    localparam sync_window_t     V_WIN    = sync_window(ACTIVE_ROWS, V_FRONT_PORCH, V_SYNC_WIDTH);
    localparam logic [COUNT_W:0] COLS_VIS = (COUNT_W+1)'(ACTIVE_COLS);
    localparam logic [COUNT_W:0] ROWS_VIS = (COUNT_W+1)'(ACTIVE_ROWS);
    localparam logic             SYNC_ON  = (SYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
    localparam logic             SYNC_OFF = ~SYNC_ON;

    logic [COUNT_W-1:0] col;
    logic [COUNT_W-1:0] row;
    logic               col_tc_c;
    logic               row_tc_c;

    vga_axis_counter #(.LIMIT(TOTAL_COLS)) u_col (
        .i_Clk        (i_Clk),
        .i_Rst_L      (i_Rst_L),
        .i_En         (i_En),
        .o_Count      (col),
        .o_Terminal_c (col_tc_c)
    );

    vga_axis_counter #(.LIMIT(TOTAL_ROWS)) u_row (
        .i_Clk        (i_Clk),
        .i_Rst_L      (i_Rst_L),
        .i_En         (i_En & col_tc_c),
        .o_Count      (row),
        .o_Terminal_c (row_tc_c)
    );

    logic [COUNT_W:0] col_x;
    logic [COUNT_W:0] row_x;
    logic             h_sync_on_c;
    logic             v_sync_on_c;
    logic             active_c;

    assign col_x       = {1'b0, col};
    assign row_x       = {1'b0, row};
    assign h_sync_on_c = (col_x >= H_WIN.start) && (col_x < H_WIN.stop);
    assign v_sync_on_c = (row_x >= V_WIN.start) && (row_x < V_WIN.stop);
    assign active_c    = (col_x < COLS_VIS) && (row_x < ROWS_VIS);

    logic               hsync_q;
    logic               vsync_q;
    logic [COUNT_W-1:0] col_q;
    logic [COUNT_W-1:0] row_q;
    logic               active_q;
    logic               frame_start_q;
    // Set when the counters sit at (0,0); replaces a pair of zero compares with the wrap carry.
    logic               origin_q;

    always_ff @(posedge i_Clk) begin : p_outputs
        if (!i_Rst_L) begin
            hsync_q       <= SYNC_OFF;
            vsync_q       <= SYNC_OFF;
            col_q         <= '0;
            row_q         <= '0;
            active_q      <= 1'b0;
            frame_start_q <= 1'b0;
            origin_q      <= 1'b1;
        end else if (i_En) begin
            hsync_q       <= h_sync_on_c ? SYNC_ON : SYNC_OFF;
            vsync_q       <= v_sync_on_c ? SYNC_ON : SYNC_OFF;
            col_q         <= col;
            row_q         <= row;
            active_q      <= active_c;
            frame_start_q <= origin_q;
            origin_q      <= col_tc_c & row_tc_c;
        end else begin
            frame_start_q <= 1'b0;
        end
    end

    assign vga.o_HSync       = hsync_q;
    assign vga.o_VSync       = vsync_q;
    assign vga.o_Col_Count   = col_q;
    assign vga.o_Row_Count   = row_q;
    assign vga.o_Active      = active_q;
    assign vga.o_Frame_Start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen: default 640x480 timing and a tiny active-high configuration.
module tb_vga_sync_gen;
    import vga_timing_pkg::*;

    typedef struct {
        int ac, hf, hw, hb, ar, vf, vw, vb;
        bit low;
    } cfg_t;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic [9:0] col;
        logic [9:0] row;
        logic       act;
        logic       fs;
    } px_t;

    // Reference: a pixel is identified by its linear index within the frame.
    function automatic int frame_len(cfg_t k);
        return (k.ac + k.hf + k.hw + k.hb) * (k.ar + k.vf + k.vw + k.vb);
    endfunction

    function automatic px_t pixel(cfg_t k, int p);
        px_t x;
        int tc, c, r;
        bit h, v;
        tc = k.ac + k.hf + k.hw + k.hb;
        c  = p % tc;
        r  = p / tc;
        h  = (c >= k.ac + k.hf) && (c < k.ac + k.hf + k.hw);
        v  = (r >= k.ar + k.vf) && (r < k.ar + k.vf + k.vw);
        x.hs  = k.low ? !h : h;
        x.vs  = k.low ? !v : v;
        x.col = 10'(c);
        x.row = 10'(r);
        x.act = (c < k.ac) && (r < k.ar);
        x.fs  = (p == 0);
        return x;
    endfunction

    function automatic px_t idle(cfg_t k);
        px_t x;
        x.hs  = k.low;
        x.vs  = k.low;
        x.col = '0;
        x.row = '0;
        x.act = 1'b0;
        x.fs  = 1'b0;
        return x;
    endfunction

    function automatic string fmt(px_t x);
        return $sformatf("hs=%b vs=%b col=%0d row=%0d act=%b fs=%b",
                         x.hs, x.vs, x.col, x.row, x.act, x.fs);
    endfunction

    logic clk   = 1'b0;
    logic rst_d = 1'b0;
    logic en_d  = 1'b1;
    logic rst_a = 1'b0;
    logic en_a  = 1'b1;

    always #5 clk = ~clk;

    vga_sync_gen_if vif_d ();
    vga_sync_gen_if vif_a ();

    vga_sync_gen u_dut_d (
        .i_Clk   (clk),
        .i_Rst_L (rst_d),
        .i_En    (en_d),
        .vga     (vif_d)
    );

    vga_sync_gen #(
        .ACTIVE_COLS     (8),
        .H_FRONT_PORCH   (2),
        .H_SYNC_WIDTH    (3),
        .H_BACK_PORCH    (2),
        .ACTIVE_ROWS     (4),
        .V_FRONT_PORCH   (1),
        .V_SYNC_WIDTH    (1),
        .V_BACK_PORCH    (1),
        .SYNC_ACTIVE_LOW (0)
    ) u_dut_a (
        .i_Clk   (clk),
        .i_Rst_L (rst_a),
        .i_En    (en_a),
        .vga     (vif_a)
    );

    cfg_t cfg_d = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b1};
    cfg_t cfg_a = '{8, 2, 3, 2, 4, 1, 1, 1, 1'b0};

    int  errors = 0;
    int  checks = 0;
    bit  done_d = 1'b0;
    bit  done_a = 1'b0;
    bit  steady_a = 1'b0;

    // Expected-response producers: one queue entry per clock edge.
    int  p_d = 0;
    int  p_a = 0;
    px_t cur_d, cur_a;
    px_t q_d[$];
    px_t q_a[$];

    always @(posedge clk) begin
        if (!rst_d) begin
            p_d   = 0;
            cur_d = idle(cfg_d);
        end else if (en_d) begin
            cur_d = pixel(cfg_d, p_d);
            p_d   = (p_d + 1) % frame_len(cfg_d);
        end else begin
            cur_d.fs = 1'b0;
        end
        q_d.push_back(cur_d);
    end

    always @(posedge clk) begin
        if (!rst_a) begin
            p_a   = 0;
            cur_a = idle(cfg_a);
        end else if (en_a) begin
            cur_a = pixel(cfg_a, p_a);
            p_a   = (p_a + 1) % frame_len(cfg_a);
        end else begin
            cur_a.fs = 1'b0;
        end
        q_a.push_back(cur_a);
    end

    task automatic check_px(input string name, input px_t got, input px_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got {%s} required {%s}", name, $time, fmt(got), fmt(exp));
        end
    endtask

    // Monitors: pop and compare what each DUT presents, sampled 1ns after the edge.
    px_t got_d, got_a;
    int  cyc_a = 0;
    int  last_fs_a = -1;

    always @(posedge clk) begin
        #1;
        got_d.hs  = vif_d.o_HSync;
        got_d.vs  = vif_d.o_VSync;
        got_d.col = vif_d.o_Col_Count;
        got_d.row = vif_d.o_Row_Count;
        got_d.act = vif_d.o_Active;
        got_d.fs  = vif_d.o_Frame_Start;
        if (q_d.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_d t=%0t got empty queue required an expected entry", $time);
        end else begin
            check_px("pix_d", got_d, q_d.pop_front());
        end
    end

    always @(posedge clk) begin
        #1;
        got_a.hs  = vif_a.o_HSync;
        got_a.vs  = vif_a.o_VSync;
        got_a.col = vif_a.o_Col_Count;
        got_a.row = vif_a.o_Row_Count;
        got_a.act = vif_a.o_Active;
        got_a.fs  = vif_a.o_Frame_Start;
        if (q_a.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_a t=%0t got empty queue required an expected entry", $time);
        end else begin
            check_px("pix_a", got_a, q_a.pop_front());
        end
        if (!steady_a) begin
            last_fs_a = -1;
        end else if (got_a.fs === 1'b1) begin
            if (last_fs_a >= 0) begin
                checks++;
                if (cyc_a - last_fs_a != 105) begin
                    errors++;
                    $display("FAIL frame_period_a got %0d required 105", cyc_a - last_fs_a);
                end
            end
            last_fs_a = cyc_a;
        end
        cyc_a++;
    end

    task automatic run_to_d(input int target, input int budget);
        int n = 0;
        while (p_d != target && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (p_d != target) begin
            errors++;
            $display("FAIL reach_d got index %0d required %0d", p_d, target);
        end
    endtask

    task automatic run_to_a(input int target, input int budget);
        int n = 0;
        while (p_a != target && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (p_a != target) begin
            errors++;
            $display("FAIL reach_a got index %0d required %0d", p_a, target);
        end
    endtask

    // Default-timing stimulus.
    initial begin
        rst_d = 1'b0;
        en_d  = 1'b1;
        repeat (3) @(negedge clk);
        rst_d = 1'b1;
        @(negedge clk);
        en_d = 1'b0;
        repeat (7) @(negedge clk);
        en_d = 1'b1;
        repeat (2 * 800 + 50) @(negedge clk);
        run_to_d(20 * 800 + 700, 20000);
        rst_d = 1'b0;
        repeat (2) @(negedge clk);
        rst_d = 1'b1;
        repeat (900) @(negedge clk);
        repeat (12000) begin
            en_d  = ($urandom_range(7) != 0);
            rst_d = ($urandom_range(4999) != 0);
            @(negedge clk);
        end
        rst_d = 1'b1;
        en_d  = 1'b1;
        repeat (4) @(negedge clk);
        done_d = 1'b1;
    end

    // Small active-high configuration: whole frames fit in a short run.
    initial begin
        rst_a = 1'b0;
        en_a  = 1'b1;
        repeat (3) @(negedge clk);
        rst_a    = 1'b1;
        steady_a = 1'b1;
        repeat (330) @(negedge clk);
        steady_a = 1'b0;
        run_to_a(4 * 15 + 9, 200);
        rst_a = 1'b0;
        repeat (2) @(negedge clk);
        rst_a = 1'b1;
        repeat (3000) begin
            en_a  = ($urandom_range(3) != 0);
            rst_a = ($urandom_range(199) != 0);
            @(negedge clk);
        end
        rst_a = 1'b1;
        en_a  = 1'b1;
        repeat (4) @(negedge clk);
        done_a = 1'b1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout required both stimulus streams complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        wait (done_d && done_a);
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
